// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver (8 data bits, LSB first) with a one-byte output buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop, reported on parityErr.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxPin,
  input  logic [15:0] baudDiv,
  output logic [7:0]  rxData,
  output logic        rxValid,
  input  logic        rxReady,
  output logic        frameErr,
`ifdef UART_RX_PARITY_EN
  output logic        parityErr,
`endif
  output logic        overrun
);

  localparam logic [4:0] OS_LAST   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] HALF_LAST = 5'((OVERSAMPLE / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_WAITHI = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  // High when data plus received parity bit hold an odd number of ones.
  function automatic logic even_par_err(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_rx_prev;
  logic [1:0]  r_settle;
  logic [15:0] r_tick_cnt;
  logic [15:0] r_div;
  logic [4:0]  r_os_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;

  logic w_rx;
  logic w_tick;
  logic w_fall;
  logic w_half_done;
  logic w_bit_done;
  logic w_start;
  logic w_os_run;
  logic w_os_wrap;
  logic w_sample_data;
  logic w_stop_eval;
  logic w_ferr;
  logic w_byte_ok;
`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic w_sample_par;
  logic w_par_bad;
  logic w_perr;
`endif

  assign w_rx        = r_sync2;
  assign w_tick      = (r_tick_cnt == r_div);
  // Edge detection is held off until the synchronizer reflects the real line after reset.
  assign w_fall      = (r_settle == 2'd3) & r_rx_prev & ~w_rx;
  assign w_half_done = w_tick & (r_os_cnt == HALF_LAST);
  assign w_bit_done  = w_tick & (r_os_cnt == OS_LAST);
  assign w_ferr      = w_stop_eval & ~w_rx;
`ifdef UART_RX_PARITY_EN
  assign w_par_bad   = even_par_err(r_shift, r_par);
  assign w_perr      = w_stop_eval & w_par_bad;
  assign w_byte_ok   = w_stop_eval & w_rx & ~w_par_bad;
`else
  assign w_byte_ok   = w_stop_eval & w_rx;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_next = S_START;
        else        w_next = S_IDLE;
      end
      S_START: begin
        if (w_half_done) w_next = w_rx ? S_IDLE : S_DATA;
        else             w_next = S_START;
      end
      S_DATA: begin
`ifdef UART_RX_PARITY_EN
        if (w_bit_done && (r_bit_cnt == 3'd7)) w_next = S_PARITY;
`else
        if (w_bit_done && (r_bit_cnt == 3'd7)) w_next = S_STOP;
`endif
        else                                   w_next = S_DATA;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_done) w_next = S_STOP;
        else            w_next = S_PARITY;
      end
`endif
      S_STOP: begin
        if (w_bit_done) w_next = w_rx ? S_IDLE : S_WAITHI;
        else            w_next = S_STOP;
      end
      S_WAITHI: begin
        if (w_rx) w_next = S_IDLE;
        else      w_next = S_WAITHI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    w_start       = 1'b0;
    w_os_run      = 1'b0;
    w_os_wrap     = 1'b0;
    w_sample_data = 1'b0;
    w_stop_eval   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_sample_par  = 1'b0;
`endif
    case (r_state)
      S_IDLE:  w_start = w_fall;
      S_START: begin
        w_os_run  = 1'b1;
        w_os_wrap = w_half_done;
      end
      S_DATA: begin
        w_os_run      = 1'b1;
        w_os_wrap     = w_bit_done;
        w_sample_data = w_bit_done;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        w_os_run     = 1'b1;
        w_os_wrap    = w_bit_done;
        w_sample_par = w_bit_done;
      end
`endif
      S_STOP: begin
        w_os_run    = 1'b1;
        w_os_wrap   = w_bit_done;
        w_stop_eval = w_bit_done;
      end
      S_WAITHI: w_os_run = 1'b0;
      default:  w_start  = 1'b0;
    endcase
  end

  // Synchronizer, baud tick generation, oversample/bit counters and data shift register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_settle   <= 2'd0;
      r_tick_cnt <= 16'd0;
      r_div      <= 16'd0;
      r_os_cnt   <= 5'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_sync1   <= rxPin;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_settle  <= (r_settle == 2'd3) ? 2'd3 : r_settle + 2'd1;
      // The divisor is only picked up at a wrap or a start-edge reload.
      if (w_start || w_tick) begin
        r_tick_cnt <= 16'd0;
        r_div      <= baudDiv;
      end else begin
        r_tick_cnt <= r_tick_cnt + 16'd1;
      end
      if (w_start || w_os_wrap) begin
        r_os_cnt <= 5'd0;
      end else if (w_tick && w_os_run) begin
        r_os_cnt <= r_os_cnt + 5'd1;
      end else begin
        r_os_cnt <= r_os_cnt;
      end
      if (w_start) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sample_data) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      if (w_sample_data) begin
        r_shift <= {w_rx, r_shift[7:1]};
      end else begin
        r_shift <= r_shift;
      end
`ifdef UART_RX_PARITY_EN
      if (w_sample_par) begin
        r_par <= w_rx;
      end else begin
        r_par <= r_par;
      end
`endif
    end
  end

  // Output buffer and error pulses; a byte arriving while the buffer is full and not being drained is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxData    <= 8'h00;
      rxValid   <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr <= 1'b0;
`endif
    end else begin
      frameErr <= w_ferr;
`ifdef UART_RX_PARITY_EN
      parityErr <= w_perr;
`endif
      if (w_byte_ok && (!rxValid || rxReady)) begin
        rxData  <= r_shift;
        rxValid <= 1'b1;
        overrun <= 1'b0;
      end else if (w_byte_ok) begin
        overrun <= 1'b1;
      end else begin
        overrun <= 1'b0;
        if (rxValid && rxReady) rxValid <= 1'b0;
        else                    rxValid <= rxValid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_uart_rx_ctrl;

  logic        clk     = 1'b0;
  logic        rstn    = 1'b0;
  logic        rxPin   = 1'b1;
  logic        rxReady = 1'b1;
  logic [15:0] baudDiv = 16'd0;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        frameErr;
  logic        overrun;
`ifdef UART_RX_PARITY_EN
  logic        parityErr;
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Posedge (counted from the start-bit negedge) at which a completed byte appears at the outputs.
  localparam int DONE_EDGE = 3 + 8 + 16 * (NBITS - 1);

  int n_checks    = 0;
  int n_errors    = 0;
  int n_valid_cyc = 0;
  int v0;
  logic [7:0] q_byte[$];
  int         q_ferr[$];
  int         q_ovr[$];
  int         q_perr[$];

  uart_rx_ctrl #(.OVERSAMPLE(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxPin    (rxPin),
    .baudDiv  (baudDiv),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxReady  (rxReady),
    .frameErr (frameErr),
`ifdef UART_RX_PARITY_EN
    .parityErr(parityErr),
`endif
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Starts at a negedge; ends at a negedge after the last bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip, input int cpb);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
    bits = {par_flip, stop_b, d, 1'b0};
`endif
    for (int i = 0; i < NBITS; i++) begin
      rxPin = bits[i];
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rxReady = v;
    @(negedge clk);
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (rxValid) n_valid_cyc++;
      if (rxValid && rxReady) begin
        if (q_byte.size() == 0) check("byte_unexpected", {24'd0, rxData}, 32'hFFFF_FFFF);
        else                    check("byte", {24'd0, rxData}, {24'd0, q_byte.pop_front()});
      end
      if (frameErr) begin
        if (q_ferr.size() == 0) check("frameErr_unexpected", 32'd1, 32'd0);
        else                    check("frameErr", 32'(frameErr), 32'(q_ferr.pop_front()));
      end
      if (overrun) begin
        if (q_ovr.size() == 0) check("overrun_unexpected", 32'd1, 32'd0);
        else                   check("overrun", 32'(overrun), 32'(q_ovr.pop_front()));
      end
`ifdef UART_RX_PARITY_EN
      if (parityErr) begin
        if (q_perr.size() == 0) check("parityErr_unexpected", 32'd1, 32'd0);
        else                    check("parityErr", 32'(parityErr), 32'(q_perr.pop_front()));
      end
`endif
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rxData", {24'd0, rxData}, 32'h00);
    check("reset_rxValid", 32'(rxValid), 32'd0);
    check("reset_frameErr", 32'(frameErr), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // 0xA5 with consumer always ready: one-cycle rxValid pulse.
    v0 = n_valid_cyc;
    q_byte.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 16);
    repeat (20) @(negedge clk);
    check("a5_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);

    // Short low glitch must not start a frame.
    v0 = n_valid_cyc;
    rxPin = 1'b0;
    repeat (4) @(negedge clk);
    rxPin = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", 32'(n_valid_cyc - v0), 32'd0);

    // Slower baud: one tick every 3 clocks.
    baudDiv = 16'd2;
    repeat (10) @(negedge clk);
    q_byte.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 48);
    repeat (60) @(negedge clk);
    baudDiv = 16'd0;
    repeat (10) @(negedge clk);

    // Stop bit low: frame error, byte dropped, line held low (break) for a while.
    v0 = n_valid_cyc;
    q_ferr.push_back(1);
    send_frame(8'h3C, 1'b0, 1'b0, 16);
    rxPin = 1'b0;
    repeat (60) @(negedge clk);
    rxPin = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_no_valid", 32'(n_valid_cyc - v0), 32'd0);
    check("ferr_q_drained", 32'(q_ferr.size()), 32'd0);

    // Overrun: buffer full with consumer stalled.
    set_ready(1'b0);
    q_byte.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 16);
    repeat (5) @(negedge clk);
    check("ovr_first_valid", 32'(rxValid), 32'd1);
    check("ovr_first_data", {24'd0, rxData}, 32'h11);
    q_ovr.push_back(1);
    send_frame(8'h22, 1'b1, 1'b0, 16);
    repeat (5) @(negedge clk);
    check("ovr_data_held", {24'd0, rxData}, 32'h11);
    check("ovr_q_drained", 32'(q_ovr.size()), 32'd0);
    set_ready(1'b1);
    set_ready(1'b0);
    check("ovr_consumed", 32'(rxValid), 32'd0);

    // Consumer drains exactly on the cycle the next byte completes.
    q_byte.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 16);
    repeat (5) @(negedge clk);
    q_byte.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, 1'b0, 16);
      begin
        repeat (DONE_EDGE - 1) @(posedge clk);
        #1 rxReady = 1'b1;
        @(posedge clk);
        #1 rxReady = 1'b0;
      end
    join
    check("same_cycle_valid", 32'(rxValid), 32'd1);
    check("same_cycle_data", {24'd0, rxData}, 32'h22);
    set_ready(1'b1);
    set_ready(1'b0);

    // Reset during data bit 3 of 0xFF while a stale byte sits in the buffer.
    send_frame(8'h33, 1'b1, 1'b0, 16);
    repeat (5) @(negedge clk);
    check("pre_reset_valid", 32'(rxValid), 32'd1);
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 16);
      begin
        repeat (66) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_rxValid", 32'(rxValid), 32'd0);
        check("rst_rxData", {24'd0, rxData}, 32'h00);
        check("rst_frameErr", 32'(frameErr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
      end
    join
    repeat (10) @(negedge clk);
    set_ready(1'b1);
`ifdef UART_RX_PARITY_EN
    q_perr.push_back(1);
    send_frame(8'h5A, 1'b1, 1'b1, 16);
`else
    q_byte.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 16);
`endif
    repeat (20) @(negedge clk);

    check("left_bytes", 32'(q_byte.size()), 32'd0);
    check("left_ferr", 32'(q_ferr.size()), 32'd0);
    check("left_ovr", 32'(q_ovr.size()), 32'd0);
    check("left_perr", 32'(q_perr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
